// File: rtl/encoder_3bit_seq_pkg.sv
// encoder_3bit_seq_pkg: shared constants, types and helpers for the sequential 8-to-3 encoder
package encoder_3bit_seq_pkg;
  localparam int N_REQ = 8;
  localparam int CODE_W = $clog2(N_REQ);
  typedef enum logic {IDLE, HOLD} state_t;
  typedef logic [CODE_W-1:0] code_t;
  function automatic logic [N_REQ-1:0] onehot(input code_t c);
    logic [N_REQ-1:0] o;
    o = '0;
    o[c] = 1'b1;
    return o;
  endfunction
endpackage

// File: rtl/encoder_3bit_seq_prio.sv
// prio_enc8: combinational 8-bit priority encoder, highest set index wins
module prio_enc8
  import encoder_3bit_seq_pkg::*;
(
  input  logic [N_REQ-1:0] v,
  output code_t            idx,
  output logic             any
);
  // scan upward so the highest set bit is the last one written
  always_comb begin
    idx = '0;
    for (int i = 0; i < N_REQ; i++) if (v[i]) idx = CODE_W'(i);
    any = |v;
  end
endmodule

// File: rtl/encoder_3bit_seq.sv
// encoder_3bit_seq: pending-set 8-to-3 priority encoder with valid/ready output; ONEHOT_CHECK_EN adds a sticky multi-hot err flag
module encoder_3bit_seq
  import encoder_3bit_seq_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] in_req,
  output logic             out_valid,
  input  logic             out_ready,
  output code_t            out_code,
  output logic [N_REQ-1:0] pend,
  output logic             err
);
  state_t           state;
  logic [N_REQ-1:0] m;
  code_t            sel;
  logic             any;
  logic             fire;
  assign m = pend | in_req;
  assign fire = (state == IDLE) || out_ready;
  prio_enc8 u_prio (
    .v  (m),
    .idx(sel),
    .any(any)
  );
  // load a new code whenever the output slot is free or being handed off; otherwise keep merging requests
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      pend <= '0;
      out_valid <= 1'b0;
      out_code <= '0;
    end else if (fire) begin
      if (any) begin
        out_code <= sel;
        pend <= m & ~onehot(sel);
        out_valid <= 1'b1;
        state <= HOLD;
      end else begin
        pend <= '0;
        out_valid <= 1'b0;
        state <= IDLE;
      end
    end else begin
      pend <= m;
    end
  end
`ifdef ONEHOT_CHECK_EN
  // sticky flag raised after any cycle with more than one request strobe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err <= 1'b0;
    else if ((in_req & (in_req - 1'b1)) != '0) err <= 1'b1;
  end
`else
  assign err = 1'b0;
`endif
endmodule

// File: tb/tb_encoder_3bit_seq.sv
// tb_encoder_3bit_seq: directed scoreboard bench for encoder_3bit_seq
module tb_encoder_3bit_seq;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] in_req = '0;
  logic       out_ready = 1'b0;
  logic       out_valid;
  logic [2:0] out_code;
  logic [7:0] pend;
  logic       err;
  int         errors = 0;
  int         checks = 0;
  logic [2:0] exp_q[$];
`ifdef ONEHOT_CHECK_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  encoder_3bit_seq dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_req   (in_req),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_code (out_code),
    .pend     (pend),
    .err      (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // monitor: every accepted code must match the head of the scoreboard
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_code: got %0d expected none", out_code);
      end else chk("code", {5'b0, out_code}, {5'b0, exp_q.pop_front()});
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    in_req = 8'hFF;
    repeat (3) tick();
    @(negedge clk);
    chk("rst_valid", {7'b0, out_valid}, 8'h00);
    chk("rst_pend", pend, 8'h00);
    chk("rst_err", {7'b0, err}, 8'h00);
    tick();
    in_req = '0;
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      @(negedge clk);
      chk("idle_valid", {7'b0, out_valid}, 8'h00);
    end
    // single request
    tick();
    out_ready = 1'b1;
    in_req = 8'h04;
    exp_q.push_back(3'd2);
    tick();
    in_req = '0;
    @(negedge clk);
    chk("single_valid", {7'b0, out_valid}, 8'h01);
    chk("single_pend", pend, 8'h00);
    chk("single_err", {7'b0, err}, 8'h00);
    tick();
    @(negedge clk);
    chk("single_done", {7'b0, out_valid}, 8'h00);
    // multi-hot strobe: err behaviour, both codes still delivered
    tick();
    in_req = 8'h11;
    exp_q.push_back(3'd4);
    exp_q.push_back(3'd0);
    tick();
    in_req = '0;
    @(negedge clk);
    chk("mh_err", {7'b0, err}, {7'b0, EXP_ERR});
    chk("mh_pend", pend, 8'h01);
    repeat (10) tick();
    @(negedge clk);
    chk("mh_err_sticky", {7'b0, err}, {7'b0, EXP_ERR});
    chk("mh_idle", {7'b0, out_valid}, 8'h00);
    // priority drain
    tick();
    in_req = 8'hA5;
    exp_q.push_back(3'd7);
    exp_q.push_back(3'd5);
    exp_q.push_back(3'd2);
    exp_q.push_back(3'd0);
    tick();
    in_req = '0;
    @(negedge clk);
    chk("drain_pend", pend, 8'h25);
    repeat (4) tick();
    @(negedge clk);
    chk("drain_done", {7'b0, out_valid}, 8'h00);
    // backpressure
    tick();
    out_ready = 1'b0;
    in_req = 8'h12;
    exp_q.push_back(3'd4);
    exp_q.push_back(3'd1);
    tick();
    in_req = '0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("bp_code", {5'b0, out_code}, 8'h04);
      chk("bp_pend", pend, 8'h02);
      tick();
    end
    out_ready = 1'b1;
    repeat (2) tick();
    @(negedge clk);
    chk("bp_done", {7'b0, out_valid}, 8'h00);
    // re-request in the handshake cycle
    tick();
    in_req = 8'h08;
    exp_q.push_back(3'd3);
    exp_q.push_back(3'd3);
    tick();
    @(negedge clk);
    chk("rr_pend", pend, 8'h00);
    tick();
    in_req = '0;
    @(negedge clk);
    chk("rr_reissue", {6'b0, out_valid, out_code == 3'd3}, 8'h03);
    tick();
    @(negedge clk);
    chk("rr_done", {7'b0, out_valid}, 8'h00);
    // re-request while held without handshake
    tick();
    out_ready = 1'b0;
    in_req = 8'h08;
    exp_q.push_back(3'd3);
    exp_q.push_back(3'd3);
    tick();
    tick();
    in_req = '0;
    @(negedge clk);
    chk("hold_rr_pend", pend, 8'h08);
    chk("hold_rr_code", {5'b0, out_code}, 8'h03);
    out_ready = 1'b1;
    repeat (2) tick();
    @(negedge clk);
    chk("hold_rr_done", {7'b0, out_valid}, 8'h00);
    // reset mid-operation drops everything
    tick();
    out_ready = 1'b0;
    in_req = 8'hC0;
    tick();
    in_req = '0;
    @(negedge clk);
    chk("mid_pend", pend, 8'h40);
    tick();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", {7'b0, out_valid}, 8'h00);
    chk("mid_rst_pend", pend, 8'h00);
    chk("mid_rst_err", {7'b0, err}, 8'h00);
    tick();
    rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    chk("post_rst_idle", {7'b0, out_valid}, 8'h00);
    chk("queue_drained", 8'(exp_q.size()), 8'h00);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
